// File: rtl/unidad_fetch.sv
// unidad_fetch: instruction-fetch stage with PC, return-address stack
// and RUN/HALT control ahead of the control unit.
module unidad_fetch #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4,
  localparam int SP_W   = $clog2(DEPTH + 1)
) (
  input  logic               reloj,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               s_inc,
  input  logic               call,
  input  logic               ret,
  input  logic               halt,
  output logic [PC_W-1:0]    pc,
  output logic [5:0]         opcode,
  output logic [SP_W-1:0]    sp,
  output logic               halted,
  output logic               stack_ovf,
  output logic               stack_udf
);

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [PC_W-1:0]   stk_q [DEPTH];
  logic              push;
  logic [PC_W-1:0]   inc;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   top;

  assign inc    = pc_q + PC_W'(1);
  assign target = instr[PC_W-1:0];

  // Most recent push lives at index sp-1.
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) top = stk_q[i];
    end
  end

  // Next-state: halt > ret > call > s_inc while running.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    if (state_q == RUN) begin
      if (halt) begin
        state_d = HALT;
      end else if (ret) begin
        if (sp_q != '0) begin
          pc_d = top;
          sp_d = sp_q - SP_W'(1);
        end else begin
          pc_d  = inc;
          udf_d = 1'b1;
        end
      end else if (call) begin
        pc_d = target;
        if (sp_q != SP_W'(DEPTH)) begin
          push = 1'b1;
          sp_d = sp_q + SP_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (s_inc) begin
        pc_d = inc;
      end else begin
        pc_d = target;
      end
    end
  end

  // State, PC, flags and stack registers.
  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && sp_q == SP_W'(i)) stk_q[i] <= inc;
      end
    end
  end

  assign pc        = pc_q;
  assign opcode    = instr[INSTR_W-1 -: 6];
  assign sp        = sp_q;
  assign halted    = (state_q == HALT);
  assign stack_ovf = ovf_q;
  assign stack_udf = udf_q;

endmodule

// File: tb/tb_unidad_fetch.sv
// tb_unidad_fetch: directed scoreboard bench for unidad_fetch.
// Expected state queued at drive time, compared after the edge.
module tb_unidad_fetch;

  logic        reloj;
  logic        reset;
  logic [15:0] instr;
  logic        s_inc, call, ret, halt;
  logic [9:0]  pc;
  logic [5:0]  opcode;
  logic [2:0]  sp;
  logic        halted, stack_ovf, stack_udf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] pc;
    logic [2:0] sp;
    logic       h;
    logic       o;
    logic       u;
    string      tag;
  } exp_t;

  exp_t sb[$];

  unidad_fetch #(
    .PC_W(10),
    .INSTR_W(16),
    .DEPTH(4)
  ) dut (
    .reloj(reloj),
    .reset(reset),
    .instr(instr),
    .s_inc(s_inc),
    .call(call),
    .ret(ret),
    .halt(halt),
    .pc(pc),
    .opcode(opcode),
    .sp(sp),
    .halted(halted),
    .stack_ovf(stack_ovf),
    .stack_udf(stack_udf)
  );

  initial begin
    reloj = 1'b0;
    forever #5 reloj = ~reloj;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic compare();
    exp_t e;
    logic [16:0] obs, req;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed none required entry");
      return;
    end
    e   = sb.pop_front();
    obs = {pc, sp, halted, stack_ovf, stack_udf};
    req = {e.pc, e.sp, e.h, e.o, e.u};
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed pc=%h sp=%0d h=%b o=%b u=%b expected pc=%h sp=%0d h=%b o=%b u=%b",
             e.tag, pc, sp, halted, stack_ovf, stack_udf,
             e.pc, e.sp, e.h, e.o, e.u);
    end
  endtask

  task automatic step(
    input logic        rst,
    input logic        inc_i,
    input logic        c,
    input logic        r,
    input logic        h,
    input logic [15:0] ins,
    input logic [9:0]  epc,
    input logic [2:0]  esp,
    input logic        eh,
    input logic        eo,
    input logic        eu,
    input string       tag
  );
    exp_t e;
    reset = rst;
    s_inc = inc_i;
    call  = c;
    ret   = r;
    halt  = h;
    instr = ins;
    e.pc = epc; e.sp = esp; e.h = eh;
    e.o = eo; e.u = eu; e.tag = tag;
    sb.push_back(e);
    @(posedge reloj);
    #1;
    compare();
  endtask

  initial begin
    reset = 1'b1; s_inc = 1'b0; call = 1'b0;
    ret = 1'b0; halt = 1'b0; instr = '0;

    step(1, 1, 0, 0, 0, 16'h0000, 10'h000, 0, 0, 0, 0, "reset");
    step(0, 1, 0, 0, 0, 16'h0000, 10'h001, 0, 0, 0, 0, "inc1");
    step(0, 1, 0, 0, 0, 16'h0000, 10'h002, 0, 0, 0, 0, "inc2");
    step(0, 1, 0, 0, 0, 16'h0000, 10'h003, 0, 0, 0, 0, "inc3");
    step(0, 0, 0, 0, 0, 16'h03FF, 10'h3FF, 0, 0, 0, 0, "jmp3ff");
    step(0, 1, 0, 0, 0, 16'h0000, 10'h000, 0, 0, 0, 0, "wrap");

    step(0, 0, 0, 0, 0, 16'h0005, 10'h005, 0, 0, 0, 0, "jmp5");
    instr = 16'hA42A;
    #1;
    checks++;
    assert (opcode === 6'h29) else begin
      errors++;
      $error("FAIL opcode observed %h expected 29", opcode);
    end
    step(0, 0, 0, 0, 0, 16'hA42A, 10'h02A, 0, 0, 0, 0, "jmp2a");

    step(0, 0, 0, 0, 0, 16'h0010, 10'h010, 0, 0, 0, 0, "jmp10");
    step(0, 1, 1, 0, 0, 16'h0100, 10'h100, 1, 0, 0, 0, "call100");
    step(0, 1, 1, 0, 0, 16'h0200, 10'h200, 2, 0, 0, 0, "call200");
    step(0, 1, 0, 1, 0, 16'h0000, 10'h101, 1, 0, 0, 0, "ret101");
    step(0, 1, 0, 1, 0, 16'h0000, 10'h011, 0, 0, 0, 0, "ret011");

    step(0, 1, 1, 0, 0, 16'h0040, 10'h040, 1, 0, 0, 0, "c40");
    step(0, 1, 1, 0, 0, 16'h0041, 10'h041, 2, 0, 0, 0, "c41");
    step(0, 1, 1, 0, 0, 16'h0042, 10'h042, 3, 0, 0, 0, "c42");
    step(0, 1, 1, 0, 0, 16'h0043, 10'h043, 4, 0, 0, 0, "c43");
    step(0, 1, 1, 0, 0, 16'h0044, 10'h044, 4, 0, 1, 0, "c44ovf");
    step(0, 1, 0, 1, 0, 16'h0000, 10'h043, 3, 0, 1, 0, "r43");
    step(0, 1, 0, 1, 0, 16'h0000, 10'h042, 2, 0, 1, 0, "r42");
    step(0, 1, 0, 1, 0, 16'h0000, 10'h041, 1, 0, 1, 0, "r41");
    step(0, 1, 0, 1, 0, 16'h0000, 10'h012, 0, 0, 1, 0, "r12");

    step(1, 0, 0, 0, 0, 16'h0000, 10'h000, 0, 0, 0, 0, "reset2");
    step(0, 0, 0, 0, 0, 16'h0007, 10'h007, 0, 0, 0, 0, "jmp7");
    step(0, 1, 0, 1, 0, 16'h0000, 10'h008, 0, 0, 0, 1, "udf");
    step(0, 1, 1, 0, 0, 16'h0050, 10'h050, 1, 0, 0, 1, "call50");
    step(0, 1, 1, 1, 0, 16'h0060, 10'h009, 0, 0, 0, 1, "callret");

    step(0, 1, 1, 0, 0, 16'h0020, 10'h020, 1, 0, 0, 1, "call20");
    step(0, 1, 1, 0, 1, 16'h0300, 10'h020, 1, 1, 0, 1, "haltcall");
    for (int i = 0; i < 10; i++) begin
      logic [3:0] v;
      v = 4'(i);
      step(0, v[0], v[1], v[2], 1'b0, 16'($urandom),
           10'h020, 1, 1, 0, 1, "halthold");
    end
    step(1, 1, 0, 0, 0, 16'h0000, 10'h000, 0, 0, 0, 0, "reset3");
    step(0, 1, 0, 0, 0, 16'h0000, 10'h001, 0, 0, 0, 0, "runagain");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed %0d expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
